// File: rtl/pc_sequencer.sv
// Fetch-stage program counter: sequential step, branch/jump/exception/ERET redirects,
// stall hold, a boot cycle after reset and a fault-hold state for illegal fetch addresses.
module pc_sequencer #(
    parameter int unsigned     WIDTH      = 32,
    parameter int unsigned     STEP       = 4,
    parameter int unsigned     ALIGN_BITS = 2,
    parameter logic [WIDTH-1:0] RESET_PC  = 32'h0000_3000,
    parameter logic [WIDTH-1:0] EXC_VEC   = 32'h0000_4180,
    parameter logic [WIDTH-1:0] PC_LO     = 32'h0000_3000,
    parameter logic [WIDTH-1:0] PC_HI     = 32'h0000_6FFC
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_stall,
    input  logic             i_br_taken,
    input  logic [WIDTH-1:0] i_br_target,
    input  logic             i_jump,
    input  logic [WIDTH-1:0] i_jump_target,
    input  logic             i_exc_req,
    input  logic             i_eret,
    input  logic [WIDTH-1:0] i_epc,
    output logic [WIDTH-1:0] o_pc,
    output logic [WIDTH-1:0] o_pc_plus_step,
    output logic             o_pc_valid,
    output logic             o_fetch_fault,
    output logic             o_redirect
);

    typedef enum logic [1:0] {
        ST_BOOT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FAULT = 2'd2
    } state_t;

    // Low-bit mask of the alignment check; an all-zero mask disables it.
    localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

    state_t           r_state;
    logic [WIDTH-1:0] r_pc;
    logic             r_redirect;

    logic             w_misalign;
    logic             w_out_of_range;
    logic             w_bad_pc;

    assign w_misalign     = |(r_pc & ALIGN_MASK);
    assign w_out_of_range = (r_pc < PC_LO) || (r_pc > PC_HI);
    assign w_bad_pc       = w_misalign || w_out_of_range;

    assign o_pc           = r_pc;
    assign o_pc_plus_step = r_pc + WIDTH'(STEP);
    assign o_fetch_fault  = (r_state != ST_BOOT) && w_bad_pc;
    assign o_pc_valid     = (r_state == ST_RUN) && !w_bad_pc;
    assign o_redirect     = r_redirect;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state    <= ST_BOOT;
            r_pc       <= RESET_PC;
            r_redirect <= 1'b0;
        end else begin
            r_redirect <= 1'b0;
            case (r_state)
                ST_BOOT: begin
                    r_state <= ST_RUN;
                end
                ST_RUN: begin
                    // Exception entry wins even over a faulting fetch.
                    if (i_exc_req) begin
                        r_pc       <= EXC_VEC;
                        r_redirect <= 1'b1;
                    end else if (w_bad_pc) begin
                        r_state <= ST_FAULT;
                    end else if (i_eret) begin
                        r_pc       <= i_epc;
                        r_redirect <= 1'b1;
                    end else if (i_stall) begin
                        r_pc <= r_pc;
                    end else if (i_jump) begin
                        r_pc       <= i_jump_target;
                        r_redirect <= 1'b1;
                    end else if (i_br_taken) begin
                        r_pc       <= i_br_target;
                        r_redirect <= 1'b1;
                    end else begin
                        r_pc <= r_pc + WIDTH'(STEP);
                    end
                end
                ST_FAULT: begin
                    if (i_exc_req) begin
                        r_state    <= ST_RUN;
                        r_pc       <= EXC_VEC;
                        r_redirect <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_BOOT;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Bench for pc_sequencer: directed scenarios with literal expectations, then random
// requests and async resets checked every cycle against a behavioural model.
module tb_pc_sequencer;

    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam logic [31:0] EXC_VEC  = 32'h0000_4180;
    localparam logic [31:0] PC_LO    = 32'h0000_3000;
    localparam logic [31:0] PC_HI    = 32'h0000_6FFC;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall, br_taken, jump, exc_req, eret;
    logic [31:0] br_target, jump_target, epc;
    logic [31:0] pc, pc_plus_step;
    logic        pc_valid, fetch_fault, redirect;

    int total = 0;
    int bad   = 0;

    // Model state: mode 0=boot, 1=running, 2=holding on a bad fetch
    int          m_mode;
    logic [31:0] m_pc;
    logic        m_redir;

    pc_sequencer dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .i_stall       (stall),
        .i_br_taken    (br_taken),
        .i_br_target   (br_target),
        .i_jump        (jump),
        .i_jump_target (jump_target),
        .i_exc_req     (exc_req),
        .i_eret        (eret),
        .i_epc         (epc),
        .o_pc          (pc),
        .o_pc_plus_step(pc_plus_step),
        .o_pc_valid    (pc_valid),
        .o_fetch_fault (fetch_fault),
        .o_redirect    (redirect)
    );

    always #5 clk = ~clk;

    function automatic bit illegal(input logic [31:0] p);
        return ((p % 32'd4) != 32'd0) || (p < PC_LO) || (p > PC_HI);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode  = 0;
        m_pc    = RESET_PC;
        m_redir = 1'b0;
    endtask

    // Apply the sequencing rules to the inputs present at this edge.
    task automatic model_edge();
        bit f;
        f       = illegal(m_pc);
        m_redir = 1'b0;
        if (m_mode == 0) begin
            m_mode = 1;
        end else if (m_mode == 2) begin
            if (exc_req) begin
                m_mode = 1; m_pc = EXC_VEC; m_redir = 1'b1;
            end
        end else begin
            if (exc_req)         begin m_pc = EXC_VEC;     m_redir = 1'b1; end
            else if (f)          m_mode = 2;
            else if (eret)       begin m_pc = epc;         m_redir = 1'b1; end
            else if (stall)      ;
            else if (jump)       begin m_pc = jump_target; m_redir = 1'b1; end
            else if (br_taken)   begin m_pc = br_target;   m_redir = 1'b1; end
            else                 m_pc = m_pc + 32'd4;
        end
    endtask

    task automatic compare_all();
        bit f;
        f = (m_mode != 0) && illegal(m_pc);
        chk("pc",           pc,           m_pc);
        chk("pc_plus_step", pc_plus_step, m_pc + 32'd4);
        chk("fetch_fault",  32'(fetch_fault), 32'(f));
        chk("pc_valid",     32'(pc_valid),    32'((m_mode == 1) && !f));
        chk("redirect",     32'(redirect),    32'(m_redir));
    endtask

    task automatic idle();
        stall = 0; br_taken = 0; jump = 0; exc_req = 0; eret = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #2;
        compare_all();
    endtask

    // Reset raised away from any clock edge; outputs must react before the next edge.
    task automatic async_reset();
        reset = 1'b1;
        #1;
        model_reset();
        compare_all();
        chk("async_pc",       pc,              RESET_PC);
        chk("async_valid",    32'(pc_valid),   32'd0);
        chk("async_redirect", 32'(redirect),   32'd0);
        #1;
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        idle();
        br_target = '0; jump_target = '0; epc = '0;
        model_reset();
        #12;
        compare_all();
        chk("reset_pc",    pc,                32'h3000);
        chk("reset_valid", 32'(pc_valid),     32'd0);
        reset = 1'b0;

        // Scenario 1: boot cycle then sequential stepping
        tick(); chk("s1_boot_pc", pc, 32'h3000); chk("s1_run_valid", 32'(pc_valid), 32'd1);
        tick(); chk("s1_pc1", pc, 32'h3004);
        tick(); chk("s1_pc2", pc, 32'h3008); chk("s1_redir", 32'(redirect), 32'd0);
        tick(); tick(); chk("s2_start", pc, 32'h3010);

        // Scenario 2: stall suppresses a jump
        stall = 1; jump = 1; jump_target = 32'h3400;
        tick(); chk("s2_hold1", pc, 32'h3010);
        tick(); chk("s2_hold2", pc, 32'h3010);
        idle();
        tick(); chk("s2_step", pc, 32'h3014);
        tick(); tick(); tick(); chk("s3_start", pc, 32'h3020);

        // Scenario 3: jump beats branch
        jump = 1; jump_target = 32'h3100; br_taken = 1; br_target = 32'h3200;
        tick(); chk("s3_pc", pc, 32'h3100); chk("s3_redir", 32'(redirect), 32'd1);
        idle();
        tick(); chk("s3_pc_next", pc, 32'h3104); chk("s3_redir_off", 32'(redirect), 32'd0);

        // Scenario 4: misaligned branch target faults, exception recovers
        br_taken = 1; br_target = 32'h3002;
        tick(); chk("s4_pc", pc, 32'h3002); chk("s4_fault", 32'(fetch_fault), 32'd1);
        chk("s4_valid", 32'(pc_valid), 32'd0);
        idle();
        tick(); tick(); tick();
        chk("s4_hold_pc", pc, 32'h3002); chk("s4_hold_fault", 32'(fetch_fault), 32'd1);
        exc_req = 1;
        tick(); chk("s4_exc_pc", pc, 32'h4180); chk("s4_exc_redir", 32'(redirect), 32'd1);
        chk("s4_exc_valid", 32'(pc_valid), 32'd1);

        // Scenario 5: exception beats eret and stall, then eret alone
        exc_req = 1; eret = 1; stall = 1; epc = 32'h3abc;
        tick(); chk("s5_exc", pc, 32'h4180);
        idle(); eret = 1;
        tick(); chk("s5_eret", pc, 32'h3abc);
        idle();

        // Wrap of the step adder at the top of the address space
        jump = 1; jump_target = 32'hFFFF_FFFC;
        tick(); chk("wrap_plus", pc_plus_step, 32'h0); chk("wrap_fault", 32'(fetch_fault), 32'd1);
        idle(); exc_req = 1;
        tick();
        idle();

        // Scenario 6: asynchronous reset mid-cycle
        jump = 1; jump_target = 32'h3500;
        tick(); chk("s6_pre", pc, 32'h3500);
        idle();
        #1;
        async_reset();
        tick(); chk("s6_boot_edge", pc, 32'h3000);

        // Random phase
        for (int n = 0; n < 3000; n++) begin
            logic [31:0] tgt [8];
            tgt[0] = 32'h0000_3000; tgt[1] = 32'h0000_6FFC; tgt[2] = 32'h0000_7000;
            tgt[3] = 32'h0000_2FFC; tgt[4] = 32'hFFFF_FFFC; tgt[5] = 32'h0000_4001;
            tgt[6] = 32'h3000 + ($urandom_range(0, 32'hFFF) << 2);
            tgt[7] = 32'h6F00 + ($urandom_range(0, 63) << 2);
            exc_req     = ($urandom_range(0, 15) == 0);
            eret        = ($urandom_range(0, 9) == 0);
            stall       = ($urandom_range(0, 3) == 0);
            jump        = ($urandom_range(0, 5) == 0);
            br_taken    = ($urandom_range(0, 5) == 0);
            jump_target = ($urandom_range(0, 1) == 0) ? tgt[$urandom_range(0, 7)] : $urandom;
            br_target   = tgt[$urandom_range(0, 7)];
            epc         = tgt[$urandom_range(0, 7)];
            tick();
            if ($urandom_range(0, 199) == 0) begin
                #1;
                async_reset();
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
